// File: rtl/memory_access_pkg.sv
// Shared types and constants for the memory-stage access controller:
// FSM states, RISC-V load/store func3 codes and byte-enable patterns.
package memory_access_pkg;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        REQUEST       = 2'd1,
        WAIT_RESPONSE = 2'd2,
        DONE          = 2'd3
    } memoryAccessState_t;

    localparam logic [2:0] FUNC3_LB  = 3'b000;
    localparam logic [2:0] FUNC3_LH  = 3'b001;
    localparam logic [2:0] FUNC3_LW  = 3'b010;
    localparam logic [2:0] FUNC3_LBU = 3'b100;
    localparam logic [2:0] FUNC3_LHU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Undefined func3 codes decode as word accesses, so they need word alignment.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] offset);
        logic result;
        case (f3)
            FUNC3_LB, FUNC3_LBU: result = 1'b0;
            FUNC3_LH, FUNC3_LHU: result = offset[0];
            default:             result = (offset != 2'b00);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/load_store_aligner.sv
// Combinational lane steering: store byte enables / replicated write data,
// and byte/halfword extraction with sign or zero extension for loads.
module load_store_aligner
    import memory_access_pkg::*;
(
    input  logic [2:0]  storeFunc3,
    input  logic [1:0]  storeOffset,
    input  logic [31:0] storeData,
    output logic [3:0]  byteEnable,
    output logic [31:0] writeData,
    input  logic [2:0]  loadFunc3,
    input  logic [1:0]  loadOffset,
    input  logic [31:0] rawData,
    output logic [31:0] loadResult
);

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    always_comb begin
        byteEnable = BE_WORD;
        writeData  = storeData;
        case (storeFunc3)
            FUNC3_LB, FUNC3_LBU: begin
                byteEnable = BE_BYTE << storeOffset;
                writeData  = {4{storeData[7:0]}};
            end
            FUNC3_LH, FUNC3_LHU: begin
                byteEnable = BE_HALF << storeOffset;
                writeData  = {2{storeData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        loadByte = rawData[7:0];
        case (loadOffset)
            2'd1:    loadByte = rawData[15:8];
            2'd2:    loadByte = rawData[23:16];
            2'd3:    loadByte = rawData[31:24];
            default: loadByte = rawData[7:0];
        endcase
        loadHalf = loadOffset[1] ? rawData[31:16] : rawData[15:0];

        case (loadFunc3)
            FUNC3_LB:  loadResult = {{24{loadByte[7]}}, loadByte};
            FUNC3_LBU: loadResult = {24'd0, loadByte};
            FUNC3_LH:  loadResult = {{16{loadHalf[15]}}, loadHalf};
            FUNC3_LHU: loadResult = {16'd0, loadHalf};
            default:   loadResult = rawData;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-stage controller: issues one data-memory access per instruction,
// stalls the pipeline while it is outstanding, and reports load/error results.
module memory_access_unit
    import memory_access_pkg::*;
#(
    parameter int RESPONSE_TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               memoryReadEnable,
    input  logic               memoryWriteEnable,
    input  logic [31:0]        alu,
    input  logic [31:0]        rs2,
    input  logic [2:0]         func3,
    output logic               dataRequestValid,
    input  logic               dataRequestReady,
    output logic               dataRequestWrite,
    output logic [31:0]        dataAddress,
    output logic [31:0]        dataWriteData,
    output logic [3:0]         dataByteEnable,
    input  logic               dataResponseValid,
    input  logic [31:0]        dataResponseData,
    output logic [31:0]        loadData,
    output logic               loadDataValid,
    output logic               stall,
    output logic               misaligned,
    output logic               busError,
    output memoryAccessState_t debugState
);

    localparam logic [7:0] TIMEOUT_COUNT = 8'(RESPONSE_TIMEOUT);

    memoryAccessState_t state, nextState;
    logic [7:0]  counter;
    logic [31:0] addressQ, writeDataQ, loadDataQ;
    logic [3:0]  byteEnableQ;
    logic [2:0]  func3Q;
    logic [1:0]  offsetQ;
    logic        writeQ, loadDoneQ, misalignedQ, busErrorQ;

    logic        accessRequested, accessMisaligned;
    logic [3:0]  alignedByteEnable;
    logic [31:0] alignedWriteData, extractedLoad;

    assign accessRequested  = memoryReadEnable | memoryWriteEnable;
    assign accessMisaligned = is_misaligned(func3, alu[1:0]);

    load_store_aligner aligner (
        .storeFunc3  (func3),
        .storeOffset (alu[1:0]),
        .storeData   (rs2),
        .byteEnable  (alignedByteEnable),
        .writeData   (alignedWriteData),
        .loadFunc3   (func3Q),
        .loadOffset  (offsetQ),
        .rawData     (dataResponseData),
        .loadResult  (extractedLoad)
    );

    // Request handshake: a transfer happens on a rising edge where
    // dataRequestValid and dataRequestReady are both 1; until then every
    // data* output holds its latched value and valid stays asserted.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:          if (accessRequested) nextState = accessMisaligned ? DONE : REQUEST;
            REQUEST:       if (dataRequestReady) nextState = writeQ ? DONE : WAIT_RESPONSE;
            WAIT_RESPONSE: if (dataResponseValid || counter == TIMEOUT_COUNT) nextState = DONE;
            DONE:          nextState = IDLE;
            default:       nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            counter     <= '0;
            addressQ    <= '0;
            writeDataQ  <= '0;
            byteEnableQ <= '0;
            func3Q      <= '0;
            offsetQ     <= '0;
            writeQ      <= 1'b0;
            loadDataQ   <= '0;
            loadDoneQ   <= 1'b0;
            misalignedQ <= 1'b0;
            busErrorQ   <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    counter     <= '0;
                    loadDoneQ   <= 1'b0;
                    misalignedQ <= 1'b0;
                    busErrorQ   <= 1'b0;
                    if (accessRequested) begin
                        if (accessMisaligned) begin
                            misalignedQ <= 1'b1;
                        end else begin
                            addressQ    <= {alu[31:2], 2'b00};
                            writeQ      <= memoryWriteEnable;
                            byteEnableQ <= alignedByteEnable;
                            writeDataQ  <= memoryWriteEnable ? alignedWriteData : 32'd0;
                            func3Q      <= func3;
                            offsetQ     <= alu[1:0];
                        end
                    end
                end
                // A response arriving in the same cycle as the timeout wins.
                WAIT_RESPONSE: begin
                    counter <= counter + 8'd1;
                    if (dataResponseValid) begin
                        loadDataQ <= extractedLoad;
                        loadDoneQ <= 1'b1;
                    end else if (counter == TIMEOUT_COUNT) begin
                        loadDataQ <= '0;
                        busErrorQ <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dataRequestValid = (state == REQUEST);
    assign dataRequestWrite = writeQ;
    assign dataAddress      = addressQ;
    assign dataWriteData    = writeDataQ;
    assign dataByteEnable   = byteEnableQ;
    assign loadData         = loadDataQ;
    assign loadDataValid    = (state == DONE) && loadDoneQ;
    assign misaligned       = (state == DONE) && misalignedQ;
    assign busError         = (state == DONE) && busErrorQ;
    assign stall            = ((state == IDLE) && accessRequested)
                              || (state == REQUEST) || (state == WAIT_RESPONSE);
    assign debugState       = state;

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: stores, loads, misalignment,
// timeout, back-to-back accesses and reset during an outstanding load.
module tb_memory_access_unit;
    import memory_access_pkg::*;

    localparam int TIMEOUT = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic memoryReadEnable = 1'b0, memoryWriteEnable = 1'b0;
    logic [31:0] alu = '0, rs2 = '0;
    logic [2:0] func3 = '0;
    logic dataRequestValid, dataRequestWrite;
    logic dataRequestReady = 1'b0;
    logic [31:0] dataAddress, dataWriteData;
    logic [3:0] dataByteEnable;
    logic dataResponseValid = 1'b0;
    logic [31:0] dataResponseData = '0;
    logic [31:0] loadData;
    logic loadDataValid, stall, misaligned, busError;
    memoryAccessState_t debugState;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [2:0] f3_tab[5] = '{FUNC3_LB, FUNC3_LH, FUNC3_LW, FUNC3_LBU, FUNC3_LHU};

    memory_access_unit #(.RESPONSE_TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .memoryReadEnable(memoryReadEnable), .memoryWriteEnable(memoryWriteEnable),
        .alu(alu), .rs2(rs2), .func3(func3),
        .dataRequestValid(dataRequestValid), .dataRequestReady(dataRequestReady),
        .dataRequestWrite(dataRequestWrite), .dataAddress(dataAddress),
        .dataWriteData(dataWriteData), .dataByteEnable(dataByteEnable),
        .dataResponseValid(dataResponseValid), .dataResponseData(dataResponseData),
        .loadData(loadData), .loadDataValid(loadDataValid), .stall(stall),
        .misaligned(misaligned), .busError(busError), .debugState(debugState)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference load extraction, written from the RISC-V definitions.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] raw);
        logic [31:0] shifted;
        shifted = raw >> (8 * off);
        case (f3)
            FUNC3_LB:  return 32'($signed(shifted[7:0]));
            FUNC3_LBU: return shifted & 32'h0000_00FF;
            FUNC3_LH:  return 32'($signed(shifted[15:0]));
            FUNC3_LHU: return shifted & 32'h0000_FFFF;
            default:   return raw;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (debugState !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", debugState, IDLE); end
        checks++;
        if ({dataRequestValid, dataRequestWrite, loadDataValid, stall, misaligned, busError} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {dataRequestValid, dataRequestWrite, loadDataValid, stall, misaligned, busError});
        end
        checks++;
        if ({dataAddress, dataWriteData, loadData, dataByteEnable} !== 100'd0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h load %h be %b expected all 0",
                     dataAddress, dataWriteData, loadData, dataByteEnable);
        end
    endtask

    task automatic test_store(input string name, input logic [31:0] addr, input logic [31:0] data,
                              input logic [2:0] f3, input logic also_read,
                              input logic [3:0] exp_be, input logic [31:0] exp_data);
        logic [31:0] exp_word;
        exp_q.push_back(exp_data);
        memoryWriteEnable = 1'b1;
        memoryReadEnable = also_read;
        alu = addr; rs2 = data; func3 = f3; dataRequestReady = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL %s_stall_c0: got %b expected 1", name, stall); end
        tick();
        checks++;
        if (dataRequestValid !== 1'b1 || dataRequestWrite !== 1'b1) begin
            errors++; $display("FAIL %s_req: valid %b write %b expected 1 1", name, dataRequestValid, dataRequestWrite);
        end
        checks++;
        if (dataAddress !== {addr[31:2], 2'b00} || dataByteEnable !== exp_be) begin
            errors++;
            $display("FAIL %s_addr_be: got %h/%b expected %h/%b", name, dataAddress, dataByteEnable,
                     {addr[31:2], 2'b00}, exp_be);
        end
        exp_word = exp_q.pop_front();
        checks++;
        if (dataWriteData !== exp_word) begin
            errors++; $display("FAIL %s_wdata: got %h expected %h", name, dataWriteData, exp_word);
        end
        tick();
        memoryWriteEnable = 1'b0;
        memoryReadEnable = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || debugState !== DONE || loadDataValid !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: stall %b state %0d ldv %b expected 0 %0d 0", name, stall, debugState,
                     loadDataValid, DONE);
        end
        tick();
    endtask

    task automatic test_load(input string name, input logic [31:0] addr, input logic [2:0] f3,
                             input logic [31:0] raw);
        logic [31:0] exp_word;
        exp_q.push_back(model_load(f3, addr[1:0], raw));
        memoryReadEnable = 1'b1;
        alu = addr; func3 = f3; dataRequestReady = 1'b1;
        tick();
        checks++;
        if (dataRequestValid !== 1'b1 || dataRequestWrite !== 1'b0 || dataAddress !== {addr[31:2], 2'b00}) begin
            errors++;
            $display("FAIL %s_req: valid %b write %b addr %h expected 1 0 %h", name, dataRequestValid,
                     dataRequestWrite, dataAddress, {addr[31:2], 2'b00});
        end
        tick();
        dataResponseValid = 1'b1;
        dataResponseData = raw;
        checks++;
        if (debugState !== WAIT_RESPONSE || stall !== 1'b1 || loadDataValid !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait: state %0d stall %b ldv %b expected %0d 1 0", name, debugState, stall,
                     loadDataValid, WAIT_RESPONSE);
        end
        tick();
        dataResponseValid = 1'b0;
        memoryReadEnable = 1'b0;
        #1;
        exp_word = exp_q.pop_front();
        checks++;
        if (loadDataValid !== 1'b1 || loadData !== exp_word || stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_data: ldv %b data %h stall %b expected 1 %h 0", name, loadDataValid, loadData,
                     stall, exp_word);
        end
        tick();
        checks++;
        if (loadDataValid !== 1'b0 || debugState !== IDLE) begin
            errors++; $display("FAIL %s_pulse: ldv %b state %0d expected 0 %0d", name, loadDataValid, debugState, IDLE);
        end
    endtask

    task automatic test_misaligned(input string name, input logic [31:0] addr, input logic [2:0] f3,
                                   input logic is_store);
        memoryReadEnable = ~is_store;
        memoryWriteEnable = is_store;
        alu = addr; func3 = f3; dataRequestReady = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1 || dataRequestValid !== 1'b0) begin
            errors++; $display("FAIL %s_c0: stall %b valid %b expected 1 0", name, stall, dataRequestValid);
        end
        tick();
        memoryReadEnable = 1'b0;
        memoryWriteEnable = 1'b0;
        #1;
        checks++;
        if (misaligned !== 1'b1 || stall !== 1'b0 || dataRequestValid !== 1'b0 || debugState !== DONE) begin
            errors++;
            $display("FAIL %s_c1: mis %b stall %b valid %b state %0d expected 1 0 0 %0d", name, misaligned, stall,
                     dataRequestValid, debugState, DONE);
        end
        tick();
        checks++;
        if (misaligned !== 1'b0 || dataRequestValid !== 1'b0) begin
            errors++; $display("FAIL %s_c2: mis %b valid %b expected 0 0", name, misaligned, dataRequestValid);
        end
    endtask

    task automatic test_timeout();
        int n;
        memoryReadEnable = 1'b1;
        alu = 32'h0000_0300; func3 = FUNC3_LW; dataRequestReady = 1'b0;
        tick();
        alu = 32'hFFFF_FFFC;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dataRequestValid !== 1'b1 || dataAddress !== 32'h0000_0300 || dataByteEnable !== 4'b1111) begin
                errors++;
                $display("FAIL timeout_hold%0d: valid %b addr %h be %b expected 1 00000300 1111", i,
                         dataRequestValid, dataAddress, dataByteEnable);
            end
            tick();
        end
        dataRequestReady = 1'b1;
        tick();
        dataRequestReady = 1'b0;
        n = 0;
        while (busError !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        memoryReadEnable = 1'b0;
        checks++;
        if (busError !== 1'b1 || n != TIMEOUT + 1) begin
            errors++; $display("FAIL timeout_cycles: busError %b after %0d cycles expected 1 after %0d", busError, n, TIMEOUT + 1);
        end
        checks++;
        if (loadData !== 32'd0 || loadDataValid !== 1'b0) begin
            errors++; $display("FAIL timeout_data: data %h ldv %b expected 00000000 0", loadData, loadDataValid);
        end
        tick();
        checks++;
        if (busError !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %b expected 0", busError); end
    endtask

    task automatic test_response_at_timeout();
        logic [31:0] exp_word;
        exp_q.push_back(32'h1357_9BDF);
        memoryReadEnable = 1'b1;
        alu = 32'h0000_0400; func3 = FUNC3_LW; dataRequestReady = 1'b1;
        tick();
        tick();
        dataRequestReady = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) tick();
        dataResponseValid = 1'b1;
        dataResponseData = 32'h1357_9BDF;
        tick();
        dataResponseValid = 1'b0;
        memoryReadEnable = 1'b0;
        exp_word = exp_q.pop_front();
        checks++;
        if (loadDataValid !== 1'b1 || busError !== 1'b0 || loadData !== exp_word) begin
            errors++;
            $display("FAIL resp_at_timeout: ldv %b berr %b data %h expected 1 0 %h", loadDataValid, busError,
                     loadData, exp_word);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3;
        logic [31:0] addr, raw, exp_word;
        dataRequestReady = 1'b1;
        memoryReadEnable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            f3 = f3_tab[$urandom_range(0, 4)];
            addr = {20'h0_0005, 10'($urandom_range(0, 1023)), 2'b00};
            if (f3 == FUNC3_LB || f3 == FUNC3_LBU) addr[1:0] = 2'($urandom_range(0, 3));
            else if (f3 == FUNC3_LH || f3 == FUNC3_LHU) addr[1] = 1'($urandom_range(0, 1));
            raw = $urandom;
            exp_q.push_back(model_load(f3, addr[1:0], raw));
            alu = addr; func3 = f3;
            tick();
            tick();
            dataResponseValid = 1'b1;
            dataResponseData = raw;
            tick();
            dataResponseValid = 1'b0;
            if (k == 3) memoryReadEnable = 1'b0;
            exp_word = exp_q.pop_front();
            checks++;
            if (loadDataValid !== 1'b1 || loadData !== exp_word) begin
                errors++;
                $display("FAIL b2b%0d_data: f3 %b addr %h ldv %b data %h expected 1 %h", k, f3, addr,
                         loadDataValid, loadData, exp_word);
            end
            tick();
            checks++;
            if (debugState !== IDLE || stall !== (k < 3)) begin
                errors++; $display("FAIL b2b%0d_idle: state %0d stall %b expected %0d %b", k, debugState, stall, IDLE, k < 3);
            end
        end
    endtask

    task automatic test_reset_midflight();
        memoryReadEnable = 1'b1;
        alu = 32'h0000_0500; func3 = FUNC3_LW; dataRequestReady = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b0;
        memoryReadEnable = 1'b0;
        tick();
        reset = 1'b1;
        dataResponseValid = 1'b1;
        dataResponseData = 32'hCAFE_F00D;
        #1;
        checks++;
        if (debugState !== IDLE || {dataRequestValid, loadDataValid, stall, misaligned, busError} !== 5'b0) begin
            errors++;
            $display("FAIL midreset_flags: state %0d flags %b expected %0d 00000", debugState,
                     {dataRequestValid, loadDataValid, stall, misaligned, busError}, IDLE);
        end
        checks++;
        if ({dataAddress, dataWriteData, loadData, dataByteEnable} !== 100'd0) begin
            errors++;
            $display("FAIL midreset_data: addr %h load %h be %b expected 0", dataAddress, loadData, dataByteEnable);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (loadDataValid !== 1'b0 || debugState !== IDLE) begin
                errors++; $display("FAIL midreset_stale%0d: ldv %b state %0d expected 0 %0d", i, loadDataValid, debugState, IDLE);
            end
        end
        dataResponseValid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store("sw", 32'h0000_0100, 32'hDEAD_BEEF, FUNC3_LW, 1'b0, 4'b1111, 32'hDEAD_BEEF);
        test_store("sb", 32'h0000_0103, 32'h0000_00A5, FUNC3_LB, 1'b0, 4'b1000, 32'hA5A5_A5A5);
        test_store("sh", 32'h0000_0102, 32'h1234_BEEF, FUNC3_LH, 1'b0, 4'b1100, 32'hBEEF_BEEF);
        test_store("sb1", 32'h0000_0101, 32'h0000_003C, FUNC3_LB, 1'b0, 4'b0010, 32'h3C3C_3C3C);
        test_store("sw_both", 32'h0000_0104, 32'h0BAD_F00D, FUNC3_LW, 1'b1, 4'b1111, 32'h0BAD_F00D);
        test_store("s_undef", 32'h0000_0108, 32'h7654_3210, 3'b011, 1'b0, 4'b1111, 32'h7654_3210);
        test_load("lb", 32'h0000_0202, FUNC3_LB, 32'h80FF_1234);
        test_load("lbu", 32'h0000_0202, FUNC3_LBU, 32'h80FF_1234);
        test_load("lh", 32'h0000_0202, FUNC3_LH, 32'h80FF_1234);
        test_load("lhu", 32'h0000_0200, FUNC3_LHU, 32'h80FF_9234);
        test_load("lw", 32'h0000_0204, FUNC3_LW, 32'h89AB_CDEF);
        test_load("l_undef", 32'h0000_0208, 3'b110, 32'h0246_8ACE);
        test_misaligned("lh_mis", 32'h0000_0201, FUNC3_LH, 1'b0);
        test_misaligned("lw_mis", 32'h0000_0202, FUNC3_LW, 1'b0);
        test_misaligned("sw_mis", 32'h0000_0103, FUNC3_LW, 1'b1);
        test_timeout();
        test_response_at_timeout();
        test_back_to_back();
        test_reset_midflight();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
